// File: rtl/pmu_counter_bank_pkg.sv
// -----------------------------------------------------------------------------
// pmu_pkg
// Shared encodings for the performance-monitor counter bank: register-select
// codes, the per-counter count-mode enum, CTRL field offsets (relative to the
// event-select width, which is a per-instance parameter) and GLOBAL bit
// positions.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package pmu_pkg;

  // Register-select field (top two address bits)
  localparam logic [1:0] SEL_CTRL = 2'd0;
  localparam logic [1:0] SEL_CNT  = 2'd1;
  localparam logic [1:0] SEL_SHD  = 2'd2;
  localparam logic [1:0] SEL_GLB  = 2'd3;

  // Per-counter count mode; RSVD counts like LEVEL
  typedef enum logic [1:0] {
    LEVEL = 2'd0,
    RISE  = 2'd1,
    FALL  = 2'd2,
    RSVD  = 2'd3
  } pmu_mode_e;

  // CTRL layout: evsel occupies [EVS_W-1:0]; the fields below sit at EVS_W+offset
  localparam int CTRL_EN_OFS   = 0;
  localparam int CTRL_MODE_OFS = 1;
  localparam int CTRL_IRQ_OFS  = 3;
  localparam int CTRL_EXTRA_W  = 4;

  // GLOBAL register bits
  localparam int GLB_FREEZE_BIT = 0;
  localparam int GLB_SNAP_BIT   = 1;
  localparam int GLB_OVFCLR_BIT = 2;
  localparam int GLB_STATUS_LSB = 3;

endpackage

// File: rtl/pmu_counter_slice.sv
// -----------------------------------------------------------------------------
// pmu_counter_slice
// One counter of the bank: CTRL fields, live count, shadow copy, event edge
// qualification, wrap detection and the sticky overflow flag.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_evt, i_evt_prev     current and previous-cycle event levels
//   i_freeze              global freeze (blocks increments only)
//   i_snap                copy live count into shadow this cycle
//   i_ovf_clr             clear sticky overflow (wins over a new overflow)
//   i_ctrl_we/i_cnt_we    CTRL / COUNT write strobes for this counter
//   i_ctrl_wdata          CTRL write data {irq_en, mode, en, evsel}
//   i_cnt_wdata           COUNT write data
//   o_ctrl                CTRL readback
//   o_count, o_shadow     live count and shadow
//   o_ovf, o_irq_en       sticky overflow flag and its interrupt enable
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pmu_counter_slice
  import pmu_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 8,
  parameter int EVS_W   = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_EVT-1:0]            i_evt,
  input  logic [NUM_EVT-1:0]            i_evt_prev,
  input  logic                          i_freeze,
  input  logic                          i_snap,
  input  logic                          i_ovf_clr,
  input  logic                          i_ctrl_we,
  input  logic                          i_cnt_we,
  input  logic [EVS_W+CTRL_EXTRA_W-1:0] i_ctrl_wdata,
  input  logic [CNT_W-1:0]              i_cnt_wdata,
  output logic [EVS_W+CTRL_EXTRA_W-1:0] o_ctrl,
  output logic [CNT_W-1:0]              o_count,
  output logic [CNT_W-1:0]              o_shadow,
  output logic                          o_ovf,
  output logic                          o_irq_en
);

  logic [EVS_W-1:0] r_evsel;
  logic             r_en;
  pmu_mode_e        r_mode;
  logic             r_irq_en;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_shadow;
  logic             r_ovf;

  logic             w_e;
  logic             w_ep;
  logic             w_hit;
  logic             w_inc;
  logic             w_wrap;
  logic [CNT_W-1:0] w_count_inc;

  // Select the chosen event and qualify it by mode; an evsel past NUM_EVT matches nothing
  always_comb begin
    w_e   = 1'b0;
    w_ep  = 1'b0;
    w_hit = 1'b0;
    for (int k = 0; k < NUM_EVT; k++) begin
      w_e  = w_e  | ((r_evsel == EVS_W'(k)) & i_evt[k]);
      w_ep = w_ep | ((r_evsel == EVS_W'(k)) & i_evt_prev[k]);
    end
    case (r_mode)
      LEVEL:   w_hit = w_e;
      RISE:    w_hit = w_e & ~w_ep;
      FALL:    w_hit = ~w_e & w_ep;
      RSVD:    w_hit = w_e;
      default: w_hit = w_e;
    endcase
  end

  assign w_inc       = r_en & ~i_freeze & w_hit;
  assign w_wrap      = &r_count;
  assign w_count_inc = r_count + CNT_W'(1);

  // CTRL fields, count, shadow and sticky overflow
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_evsel  <= '0;
      r_en     <= 1'b0;
      r_mode   <= LEVEL;
      r_irq_en <= 1'b0;
      r_count  <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (i_ctrl_we) begin
        r_evsel  <= i_ctrl_wdata[EVS_W-1:0];
        r_en     <= i_ctrl_wdata[EVS_W+CTRL_EN_OFS];
        r_mode   <= pmu_mode_e'(i_ctrl_wdata[EVS_W+CTRL_MODE_OFS +: 2]);
        r_irq_en <= i_ctrl_wdata[EVS_W+CTRL_IRQ_OFS];
      end
      // A software write replaces the increment and suppresses its overflow
      if (i_cnt_we) begin
        r_count <= i_cnt_wdata;
      end else if (w_inc) begin
        r_count <= w_count_inc;
      end
      // Shadow captures the value held before this cycle's increment or write
      if (i_snap) begin
        r_shadow <= r_count;
      end
      // Clear wins over an overflow in the same cycle
      if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end else if (w_inc && w_wrap && !i_cnt_we) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_ctrl   = {r_irq_en, r_mode, r_en, r_evsel};
  assign o_count  = r_count;
  assign o_shadow = r_shadow;
  assign o_ovf    = r_ovf;
  assign o_irq_en = r_irq_en;

endmodule

// File: rtl/pmu_counter_bank.sv
// -----------------------------------------------------------------------------
// pmu_counter_bank
// NUM_CNT event counters with per-counter event select and count mode,
// sticky overflow with interrupt, global freeze, atomic snapshot, and a
// registered single-port register interface.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   evt_i         event levels (bit 0 tied high as the cycle event)
//   wr_en, rd_en  register write / read strobes (may be asserted together)
//   addr          {sel[1:0], idx}
//   wdata         write data
//   rdata         read data, valid the cycle after rd_en, held otherwise
//   rd_valid      one-cycle pulse following rd_en
//   ovf_irq       registered |(ovf_sticky & irq_en)
//   ovf_status    sticky overflow flags
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module pmu_counter_bank
  import pmu_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 8,
  parameter int IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  parameter int EVS_W   = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [IDX_W+1:0]   addr,
  input  logic [CNT_W-1:0]   wdata,
  output logic [CNT_W-1:0]   rdata,
  output logic               rd_valid,
  output logic               ovf_irq,
  output logic [NUM_CNT-1:0] ovf_status
);

  localparam int CTRL_W = EVS_W + CTRL_EXTRA_W;
  localparam int GLB_W  = NUM_CNT + GLB_STATUS_LSB;

  logic [NUM_EVT-1:0] r_evt_prev;
  logic               r_freeze;
  logic [CNT_W-1:0]   r_rdata;
  logic               r_rd_valid;
  logic               r_ovf_irq;

  logic [1:0]         w_sel;
  logic [IDX_W-1:0]   w_idx;
  logic [NUM_CNT-1:0] w_dec;
  logic               w_glb_we;
  logic               w_snap;
  logic               w_ovf_clr;
  logic [CTRL_W-1:0]  w_ctrl_wdata;
  logic [NUM_CNT-1:0] w_ovf;
  logic [NUM_CNT-1:0] w_irq_en;
  logic [CNT_W-1:0]   w_ctrl_rd [NUM_CNT];
  logic [CNT_W-1:0]   w_count   [NUM_CNT];
  logic [CNT_W-1:0]   w_shadow  [NUM_CNT];
  logic [GLB_W-1:0]   w_glb_raw;
  logic [CNT_W-1:0]   w_glb_rd;
  logic [CNT_W-1:0]   w_rd_data;

  assign w_sel     = addr[IDX_W+1:IDX_W];
  assign w_idx     = addr[IDX_W-1:0];
  assign w_glb_we  = wr_en & (w_sel == SEL_GLB);
  assign w_snap    = w_glb_we & wdata[GLB_SNAP_BIT];
  assign w_ovf_clr = w_glb_we & wdata[GLB_OVFCLR_BIT];
  assign w_glb_raw = {w_ovf, 2'b00, r_freeze};

  // CTRL and GLOBAL images are fitted to the data-bus width (zero-extend or truncate)
  if (CNT_W >= CTRL_W) begin : g_ctrl_w_fit
    assign w_ctrl_wdata = wdata[CTRL_W-1:0];
  end else begin : g_ctrl_w_ext
    assign w_ctrl_wdata = CTRL_W'(wdata);
  end

  if (CNT_W >= GLB_W) begin : g_glb_ext
    assign w_glb_rd = CNT_W'(w_glb_raw);
  end else begin : g_glb_trunc
    assign w_glb_rd = w_glb_raw[CNT_W-1:0];
  end

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    logic [CTRL_W-1:0] w_ctrl;

    // Indices at or above NUM_CNT decode to no counter
    assign w_dec[gi] = (w_idx == IDX_W'(gi));

    pmu_counter_slice #(
      .CNT_W   (CNT_W),
      .NUM_EVT (NUM_EVT),
      .EVS_W   (EVS_W)
    ) u_slice (
      .i_clk        (clk),
      .i_rst_n      (rst),
      .i_evt        (evt_i),
      .i_evt_prev   (r_evt_prev),
      .i_freeze     (r_freeze),
      .i_snap       (w_snap),
      .i_ovf_clr    (w_ovf_clr),
      .i_ctrl_we    (wr_en & (w_sel == SEL_CTRL) & w_dec[gi]),
      .i_cnt_we     (wr_en & (w_sel == SEL_CNT) & w_dec[gi]),
      .i_ctrl_wdata (w_ctrl_wdata),
      .i_cnt_wdata  (wdata),
      .o_ctrl       (w_ctrl),
      .o_count      (w_count[gi]),
      .o_shadow     (w_shadow[gi]),
      .o_ovf        (w_ovf[gi]),
      .o_irq_en     (w_irq_en[gi])
    );

    if (CNT_W >= CTRL_W) begin : g_ctrl_r_ext
      assign w_ctrl_rd[gi] = CNT_W'(w_ctrl);
    end else begin : g_ctrl_r_trunc
      assign w_ctrl_rd[gi] = w_ctrl[CNT_W-1:0];
    end
  end

  // Read mux over the register state before any same-cycle write
  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      SEL_CTRL: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          w_rd_data = w_rd_data | ({CNT_W{w_dec[i]}} & w_ctrl_rd[i]);
        end
      end
      SEL_CNT: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          w_rd_data = w_rd_data | ({CNT_W{w_dec[i]}} & w_count[i]);
        end
      end
      SEL_SHD: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          w_rd_data = w_rd_data | ({CNT_W{w_dec[i]}} & w_shadow[i]);
        end
      end
      SEL_GLB: w_rd_data = w_glb_rd;
      default: w_rd_data = '0;
    endcase
  end

  // Previous event levels always track, so unfreezing never fabricates an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_evt_prev <= '0;
      r_freeze   <= 1'b0;
    end else begin
      r_evt_prev <= evt_i;
      if (w_glb_we) begin
        r_freeze <= wdata[GLB_FREEZE_BIT];
      end
    end
  end

  // Registered read port and interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
      r_ovf_irq  <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rdata <= w_rd_data;
      end
      r_ovf_irq <= |(w_ovf & w_irq_en);
    end
  end

  assign rdata      = r_rdata;
  assign rd_valid   = r_rd_valid;
  assign ovf_irq    = r_ovf_irq;
  assign ovf_status = w_ovf;

endmodule

// File: tb/tb_pmu_counter_bank.sv
`timescale 1ns/1ps
module tb_pmu_counter_bank;

  localparam logic [1:0] S_CTRL = 2'd0;
  localparam logic [1:0] S_CNT  = 2'd1;
  localparam logic [1:0] S_SHD  = 2'd2;
  localparam logic [1:0] S_GLB  = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  evt_i;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  addr;
  logic [31:0] wdata;

  logic [31:0] rdata;
  logic        rd_valid;
  logic        ovf_irq;
  logic [3:0]  ovf_status;

  logic [7:0]  rdata8;
  logic        rd_valid8;
  logic        ovf_irq8;
  logic [2:0]  ovf_status8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pmu_counter_bank #(.NUM_CNT(4), .CNT_W(32), .NUM_EVT(8)) dut (
    .clk(clk), .rst(rst), .evt_i(evt_i), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid),
    .ovf_irq(ovf_irq), .ovf_status(ovf_status)
  );

  // 8-bit, 3-counter build: shares the bus, used for wrap and invalid-index checks
  pmu_counter_bank #(.NUM_CNT(3), .CNT_W(8), .NUM_EVT(8)) dut8 (
    .clk(clk), .rst(rst), .evt_i(evt_i), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata[7:0]), .rdata(rdata8), .rd_valid(rd_valid8),
    .ovf_irq(ovf_irq8), .ovf_status(ovf_status8)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [1:0] idx, input logic [31:0] d);
    addr  = {sel, idx};
    wdata = d;
    wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [1:0] idx);
    addr  = {sel, idx};
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (ovf_irq !== 1'b0) begin errors++; $display("FAIL reset_ovf_irq: got %b expected 0", ovf_irq); end
    checks++; if (ovf_status !== 4'h0) begin errors++; $display("FAIL reset_ovf_status: got %h expected 0", ovf_status); end
    rst = 1'b1;
    tick(10);
    rd(S_CNT, 2'd0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL idle_count0: got %h expected %h", rdata, 32'h0); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL idle_rd_valid: got %b expected 1", rd_valid); end
    evt_i = 8'h01;
  endtask

  task automatic test_level();
    wr(S_CTRL, 2'd0, 32'h08);   // evsel 0, LEVEL, en
    tick(99);
    wr(S_GLB, 2'd0, 32'h1);     // freeze; this edge still counts (100th)
    rd(S_CNT, 2'd0);
    checks++; if (rdata !== 32'd100) begin errors++; $display("FAIL level_100: got %0d expected 100", rdata); end
    rd(S_GLB, 2'd0);
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL global_freeze_rd: got %h expected 1", rdata); end
    wr(S_GLB, 2'd0, 32'h0);
    tick(4);
    wr(S_GLB, 2'd0, 32'h1);
    rd(S_CNT, 2'd0);
    checks++; if (rdata !== 32'd105) begin errors++; $display("FAIL level_105: got %0d expected 105", rdata); end
  endtask

  task automatic test_rise();
    wr(S_GLB, 2'd0, 32'h0);
    wr(S_CTRL, 2'd1, 32'h1B);   // evsel 3, RISE, en
    rd(S_CTRL, 2'd1);
    checks++; if (rdata !== 32'h1B) begin errors++; $display("FAIL ctrl1_rd: got %h expected %h", rdata, 32'h1B); end
    for (int p = 0; p < 3; p++) begin
      evt_i[3] = 1'b1;
      tick(4);
      evt_i[3] = 1'b0;
      tick(4);
    end
    wr(S_GLB, 2'd0, 32'h1);
    evt_i[3] = 1'b1;
    tick(3);
    wr(S_GLB, 2'd0, 32'h0);
    tick(3);
    evt_i[3] = 1'b0;
    tick(2);
    rd(S_CNT, 2'd1);
    checks++; if (rdata !== 32'd3) begin errors++; $display("FAIL rise_count: got %0d expected 3", rdata); end
  endtask

  task automatic test_overflow();
    wr(S_CNT, 2'd2, 32'hFE);
    wr(S_CTRL, 2'd2, 32'h48);   // evsel 0, LEVEL, en, irq_en
    tick(2);
    checks++; if (ovf_status8[2] !== 1'b1) begin errors++; $display("FAIL ovf8_status: got %b expected 1", ovf_status8[2]); end
    checks++; if (ovf_irq8 !== 1'b0) begin errors++; $display("FAIL ovf8_irq_early: got %b expected 0", ovf_irq8); end
    rd(S_CNT, 2'd2);
    checks++; if (rdata8 !== 8'h00) begin errors++; $display("FAIL ovf8_wrap: got %h expected 00", rdata8); end
    checks++; if (ovf_irq8 !== 1'b1) begin errors++; $display("FAIL ovf8_irq: got %b expected 1", ovf_irq8); end
    checks++; if (ovf_irq !== 1'b0) begin errors++; $display("FAIL ovf32_no_irq: got %b expected 0", ovf_irq); end
    wr(S_CTRL, 2'd2, 32'h0);
    wr(S_GLB, 2'd0, 32'h4);     // ovf_clear
    checks++; if (ovf_status8[2] !== 1'b0) begin errors++; $display("FAIL ovf8_clear: got %b expected 0", ovf_status8[2]); end
    tick(1);
    checks++; if (ovf_irq8 !== 1'b0) begin errors++; $display("FAIL ovf8_irq_clear: got %b expected 0", ovf_irq8); end
    // Full-width wrap with irq disabled
    wr(S_CNT, 2'd3, 32'hFFFF_FFFF);
    wr(S_CTRL, 2'd3, 32'h08);
    tick(1);
    checks++; if (ovf_status[3] !== 1'b1) begin errors++; $display("FAIL ovf32_status: got %b expected 1", ovf_status[3]); end
    rd(S_CNT, 2'd3);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL ovf32_wrap: got %h expected 0", rdata); end
    checks++; if (ovf_irq !== 1'b0) begin errors++; $display("FAIL ovf32_irq_masked: got %b expected 0", ovf_irq); end
  endtask

  task automatic test_snapshot();
    wr(S_CNT, 2'd0, 32'd1000);
    tick(4);
    wr(S_GLB, 2'd0, 32'h2);     // snapshot captures 1004
    rd(S_SHD, 2'd0);
    checks++; if (rdata !== 32'd1004) begin errors++; $display("FAIL snap_shadow: got %0d expected 1004", rdata); end
    rd(S_CNT, 2'd0);
    checks++; if (rdata !== 32'd1006) begin errors++; $display("FAIL snap_count_runs: got %0d expected 1006", rdata); end
    wr(S_CNT, 2'd0, 32'd7);
    rd(S_SHD, 2'd0);
    checks++; if (rdata !== 32'd1004) begin errors++; $display("FAIL snap_shadow_hold: got %0d expected 1004", rdata); end
    rd(S_CNT, 2'd0);
    checks++; if (rdata !== 32'd8) begin errors++; $display("FAIL snap_count_write: got %0d expected 8", rdata); end
  endtask

  task automatic test_back_to_back();
    wr(S_CNT, 2'd0, 32'h55);    // write beats the increment of the same cycle
    rd(S_CNT, 2'd0);
    checks++; if (rdata !== 32'h55) begin errors++; $display("FAIL write_beats_inc: got %h expected 55", rdata); end
    addr  = {S_CNT, 2'd1};
    wdata = 32'hABCD;
    wr_en = 1'b1;
    rd_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
    rd_en = 1'b0;
    checks++; if (rdata !== 32'd3) begin errors++; $display("FAIL rd_before_wr: got %h expected 3", rdata); end
    rd(S_CNT, 2'd1);
    checks++; if (rdata !== 32'hABCD) begin errors++; $display("FAIL wr_then_rd: got %h expected ABCD", rdata); end
    tick(1);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid); end
    checks++; if (rdata !== 32'hABCD) begin errors++; $display("FAIL rdata_hold: got %h expected ABCD", rdata); end
    rd(S_CNT, 2'd3);            // idx 3 does not exist in the 3-counter build
    checks++; if (rdata8 !== 8'h00) begin errors++; $display("FAIL bad_idx_rdata: got %h expected 00", rdata8); end
    checks++; if (rd_valid8 !== 1'b1) begin errors++; $display("FAIL bad_idx_rd_valid: got %b expected 1", rd_valid8); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    evt_i = 8'hFF;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr  = 4'h0;
    wdata = 32'h0;
    rst   = 1'b0;
    tick(3);
    test_reset();
    test_level();
    test_rise();
    test_overflow();
    test_snapshot();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
